decode_pipe: RTL and testbench

Registered main-decode stage for the MIPS core. It decodes the 6-bit primary opcode into the control bundle consumed by execute/memory/writeback, with an optional extended opcode set. The decoded bundle and the instruction's PC travel through a two-entry skid buffer, so decode sustains one instruction per cycle under valid/ready backpressure. The block also supports pipeline flush and keeps a saturating count of illegal opcodes. It sits between the IF/ID register and the ID/EX consumer.

---
 rtl/decode_pipe.sv | 98 +++++++++
 tb/tb_decode_pipe.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// decode_pipe: registered MIPS main decoder behind a two-entry skid buffer with flush and an illegal-opcode counter.
module decode_pipe #(
  parameter int PC_W   = 32,
  parameter bit EXT_EN = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_op,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic             regwrite,
  output logic             regdst,
  output logic             alusrc,
  output logic             branch,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             jump,
  output logic             bne,
  output logic             link,
  output logic             membyte,
  output logic             illegal,
  output logic [3:0]       aluop,
  output logic [CNT_W-1:0] illegal_cnt
);
  // bundle layout: {regwrite,regdst,alusrc,branch,memwrite,memtoreg,jump, aluop, bne,link,membyte,illegal}
  logic [14:0] dec, main_b, skid_b;
  logic [PC_W-1:0] main_pc, skid_pc;
  logic main_v, skid_v, take, load_main;
  logic [CNT_W-1:0] cnt;
  always_comb begin
    dec = {7'b0000000, 4'b1111, 4'b0001};
    case (in_op)
      6'b000000: dec = {7'b1100000, 4'b1000, 4'b0000};
      6'b100011: dec = {7'b1010010, 4'b0100, 4'b0000};
      6'b101011: dec = {7'b0010100, 4'b0100, 4'b0000};
      6'b000100: dec = {7'b0001000, 4'b1011, 4'b0000};
      6'b001000: dec = {7'b1010000, 4'b0100, 4'b0000};
      6'b001001: dec = {7'b1010000, 4'b0101, 4'b0000};
      6'b001010: dec = {7'b1010000, 4'b0110, 4'b0000};
      6'b001011: dec = {7'b1010000, 4'b0111, 4'b0000};
      6'b001100: dec = {7'b1010000, 4'b0000, 4'b0000};
      6'b001110: dec = {7'b1010000, 4'b0001, 4'b0000};
      6'b001111: dec = {7'b1010000, 4'b0010, 4'b0000};
      6'b001101: dec = {7'b1010000, 4'b0011, 4'b0000};
      6'b000010: dec = {7'b0000001, 4'b0100, 4'b0000};
      6'b000101: if (EXT_EN) dec = {7'b0001000, 4'b1011, 4'b1000};
      6'b000011: if (EXT_EN) dec = {7'b1000001, 4'b0100, 4'b0100};
      6'b100000: if (EXT_EN) dec = {7'b1010010, 4'b0100, 4'b0010};
      6'b101000: if (EXT_EN) dec = {7'b0010100, 4'b0100, 4'b0010};
      default: ;
    endcase
  end
  assign take      = in_valid & ~skid_v;
  assign load_main = ~main_v | out_ready;
  // skid is only ever valid while main is valid, so main always refills from skid first
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      main_b  <= '0;
      skid_b  <= '0;
      main_pc <= '0;
      skid_pc <= '0;
      cnt     <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      if (load_main) begin
        main_v <= skid_v | take;
        skid_v <= 1'b0;
        if (skid_v) begin
          main_b  <= skid_b;
          main_pc <= skid_pc;
        end else if (take) begin
          main_b  <= dec;
          main_pc <= in_pc;
        end
      end else if (take) begin
        skid_v  <= 1'b1;
        skid_b  <= dec;
        skid_pc <= in_pc;
      end
      if (take & dec[0] & ~&cnt) cnt <= cnt + CNT_W'(1);
    end
  end
  assign {regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump, aluop, bne, link, membyte, illegal} = main_b;
  assign out_valid   = main_v;
  assign out_pc      = main_pc;
  assign in_ready    = ~skid_v;
  assign illegal_cnt = cnt;
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed checks of decode_pipe in three configurations (ext on, ext off, 2-bit counter).
module tb_decode_pipe;
  logic clk = 1'b0, rst, flush, in_valid, out_ready;
  logic [5:0] in_op;
  logic [31:0] in_pc;
  logic [14:0] bun [3];
  logic [31:0] opc [3];
  logic ov [3], ir [3];
  logic [7:0] cnt [3];
  int total = 0, passed = 0;
  localparam logic [14:0] ILL = {7'b0000000, 4'b1111, 4'b0001};
  localparam logic [5:0] BOP [13] = '{6'o00, 6'o43, 6'o53, 6'o04, 6'o10, 6'o11, 6'o12, 6'o13, 6'o14, 6'o16, 6'o17, 6'o15, 6'o02};
  localparam logic [14:0] BEXP [13] = '{
    15'b1100000_1000_0000, 15'b1010010_0100_0000, 15'b0010100_0100_0000, 15'b0001000_1011_0000,
    15'b1010000_0100_0000, 15'b1010000_0101_0000, 15'b1010000_0110_0000, 15'b1010000_0111_0000,
    15'b1010000_0000_0000, 15'b1010000_0001_0000, 15'b1010000_0010_0000, 15'b1010000_0011_0000,
    15'b0000001_0100_0000};
  localparam logic [5:0] XOP [4] = '{6'b000101, 6'b000011, 6'b100000, 6'b101000};
  localparam logic [14:0] XEXP [4] = '{15'b0001000_1011_1000, 15'b1000001_0100_0100,
    15'b1010010_0100_0010, 15'b0010100_0100_0010};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int CW = g == 2 ? 2 : 8;
    logic [CW-1:0] c;
    decode_pipe #(.PC_W(32), .EXT_EN(g != 1), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[g]),
      .in_op(in_op), .in_pc(in_pc), .out_valid(ov[g]), .out_ready(out_ready), .out_pc(opc[g]),
      .regwrite(bun[g][14]), .regdst(bun[g][13]), .alusrc(bun[g][12]), .branch(bun[g][11]),
      .memwrite(bun[g][10]), .memtoreg(bun[g][9]), .jump(bun[g][8]), .aluop(bun[g][7:4]),
      .bne(bun[g][3]), .link(bun[g][2]), .membyte(bun[g][1]), .illegal(bun[g][0]),
      .illegal_cnt(c));
    assign cnt[g] = 8'(c);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [5:0] op, input logic [31:0] pc);
    in_valid = 1'b1;
    in_op = op;
    in_pc = pc;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_op = 6'h3f; in_pc = '0;
    repeat (2) step();
    chk("rst_ov", 32'(ov[0]), 0);
    chk("rst_ir", 32'(ir[0]), 1);
    chk("rst_bun", 32'(bun[0]), 0);
    chk("rst_pc", opc[0], 0);
    chk("rst_cnt", 32'(cnt[0]), 0);
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      send(BOP[i], 32'(i * 4));
      chk($sformatf("base%0d_ov", i), 32'(ov[0]), 1);
      chk($sformatf("base%0d_pc", i), opc[0], 32'(i * 4));
      chk($sformatf("base%0d_bun", i), 32'(bun[0]), 32'(BEXP[i]));
      chk($sformatf("base%0d_bun_noext", i), 32'(bun[1]), 32'(BEXP[i]));
    end
    chk("base_cnt", 32'(cnt[0]), 0);
    for (int i = 0; i < 4; i++) begin
      send(XOP[i], 32'h40 + 32'(i * 4));
      chk($sformatf("ext%0d_bun", i), 32'(bun[0]), 32'(XEXP[i]));
      chk($sformatf("ext%0d_bun_noext", i), 32'(bun[1]), 32'(ILL));
    end
    chk("ext_cnt_on", 32'(cnt[0]), 0);
    chk("ext_cnt_off", 32'(cnt[1]), 4);
    in_valid = 1'b0;
    step();
    chk("drain_ov", 32'(ov[0]), 0);
    out_ready = 1'b0;
    send(6'o00, 32'h100);
    chk("bp_ov", 32'(ov[0]), 1);
    chk("bp_ir1", 32'(ir[0]), 1);
    send(6'o00, 32'h104);
    chk("bp_ir0", 32'(ir[0]), 0);
    chk("bp_pc_a", opc[0], 32'h100);
    send(6'o00, 32'h108);
    chk("bp_ir_hold", 32'(ir[0]), 0);
    chk("bp_pc_stable", opc[0], 32'h100);
    out_ready = 1'b1;
    step();
    chk("bp_pc_b", opc[0], 32'h104);
    chk("bp_ir_back", 32'(ir[0]), 1);
    step();
    chk("bp_pc_c", opc[0], 32'h108);
    chk("bp_ov_c", 32'(ov[0]), 1);
    in_valid = 1'b0;
    step();
    chk("bp_empty", 32'(ov[0]), 0);
    out_ready = 1'b0;
    send(6'o00, 32'h200);
    send(6'o00, 32'h204);
    chk("fl_full", 32'(ir[0]), 0);
    flush = 1'b1;
    send(6'h3f, 32'h208);
    chk("fl_ov", 32'(ov[0]), 0);
    chk("fl_ir", 32'(ir[0]), 1);
    send(6'h3f, 32'h20c);
    chk("fl_ov2", 32'(ov[0]), 0);
    chk("fl_cnt_on", 32'(cnt[0]), 0);
    chk("fl_cnt_off", 32'(cnt[1]), 4);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("fl_gone", 32'(ov[0]), 0);
    step();
    chk("fl_gone2", 32'(ov[0]), 0);
    for (int i = 0; i < 5; i++) begin
      send(6'h3f, 32'h300 + 32'(i * 4));
      chk($sformatf("sat%0d", i), 32'(cnt[2]), i < 3 ? i + 1 : 3);
      chk($sformatf("cnt8_%0d", i), 32'(cnt[0]), 32'(i + 1));
    end
    chk("ill_bun", 32'(bun[0]), 32'(ILL));
    chk("cnt_off", 32'(cnt[1]), 9);
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    send(6'o00, 32'h400);
    send(6'o00, 32'h404);
    rst = 1'b1; flush = 1'b1;
    send(6'o43, 32'h408);
    chk("rr_ov", 32'(ov[0]), 0);
    chk("rr_ir", 32'(ir[0]), 1);
    chk("rr_bun", 32'(bun[0]), 0);
    chk("rr_pc", opc[0], 0);
    chk("rr_cnt", 32'(cnt[0]), 0);
    chk("rr_cnt2", 32'(cnt[2]), 0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();
    chk("rr_idle", 32'(ov[0]), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
